// File: rtl/router_pkt_gen.sv
// router_pkt_gen: ingress packet builder feeding the 1x3 router.
// A request (destination, length) opens a load window in which the host
// streams payload bytes over a valid/ready port. Once the whole payload is
// buffered, the block emits header, payload and parity bytes on the router's
// pkt_valid/data_in pair, honouring the router's busy back-pressure, and then
// holds an inter-packet gap before accepting the next request.
//
// Handshakes:
//   host side  : a payload byte transfers on a rising edge where s_valid=1 and
//                s_ready=1; s_ready is high only in LOAD.
//   router side: the byte on pkt_data is taken on a rising edge where busy=0
//                and the state is HDR, PAY or PAR; pkt_data/pkt_valid are
//                registers that advance to the next byte on that same edge and
//                are otherwise held, so busy never reaches the outputs
//                combinationally.
module router_pkt_gen #(
    parameter int GAP_CYCLES   = 2,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pay_len,
    input  logic       corrupt_par,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       busy,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    output logic       tx_active,
    output logic       done,
    output logic       bad_req,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HDR  = 3'd2,
        S_PAY  = 3'd3,
        S_PAR  = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    // Terminal counts; the timeout value is unused when LOAD_TIMEOUT is 0.
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(LOAD_TIMEOUT - 1);

    state_t     state, state_n;
    logic [5:0] len_q, len_n;
    logic [1:0] addr_q, addr_n;
    logic       corrupt_q, corrupt_n;
    logic [5:0] wr_idx, wr_idx_n;
    logic [5:0] rd_idx, rd_idx_n;
    logic [7:0] par_q, par_n;
    logic [7:0] gap_cnt, gap_n;
    logic [7:0] to_cnt, to_n;
    logic [7:0] pkt_data_n;
    logic       pkt_valid_n;
    logic       done_n;
    logic       bad_req_n;
    logic       buf_we;

    logic [7:0] buf_mem [0:63];

    assign s_ready   = (state == S_LOAD);
    assign tx_active = (state != S_IDLE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state and next-value logic for the whole datapath.
    always_comb begin
        state_n     = state;
        len_n       = len_q;
        addr_n      = addr_q;
        corrupt_n   = corrupt_q;
        wr_idx_n    = wr_idx;
        rd_idx_n    = rd_idx;
        par_n       = par_q;
        gap_n       = gap_cnt;
        to_n        = to_cnt;
        pkt_data_n  = pkt_data;
        pkt_valid_n = pkt_valid;
        done_n      = 1'b0;
        bad_req_n   = 1'b0;
        buf_we      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (dest_addr == 2'd3 || pay_len == 6'd0) begin
                        bad_req_n = 1'b1;
                    end else begin
                        len_n     = pay_len;
                        addr_n    = dest_addr;
                        corrupt_n = corrupt_par;
                        par_n     = {pay_len, dest_addr};
                        wr_idx_n  = 6'd0;
                        to_n      = 8'd0;
                        state_n   = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (s_valid) begin
                    buf_we   = 1'b1;
                    par_n    = par_q ^ s_data;
                    wr_idx_n = wr_idx + 6'd1;
                    to_n     = 8'd0;
                    if (wr_idx == len_q - 6'd1) begin
                        // Header is ready the cycle after the last payload byte.
                        pkt_data_n  = {len_q, addr_q};
                        pkt_valid_n = 1'b1;
                        state_n     = S_HDR;
                    end
                end else if (LOAD_TIMEOUT != 0) begin
                    if (to_cnt == TO_LAST) begin
                        bad_req_n = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        to_n = to_cnt + 8'd1;
                    end
                end
            end
            S_HDR: begin
                if (!busy) begin
                    pkt_data_n = buf_mem[6'd0];
                    rd_idx_n   = 6'd0;
                    state_n    = S_PAY;
                end
            end
            S_PAY: begin
                if (!busy) begin
                    if (rd_idx == len_q - 6'd1) begin
                        // Parity byte travels with pkt_valid low.
                        pkt_data_n  = par_q ^ {7'b0, corrupt_q};
                        pkt_valid_n = 1'b0;
                        state_n     = S_PAR;
                    end else begin
                        pkt_data_n = buf_mem[rd_idx + 6'd1];
                        rd_idx_n   = rd_idx + 6'd1;
                    end
                end
            end
            S_PAR: begin
                if (!busy) begin
                    pkt_data_n = 8'd0;
                    done_n     = 1'b1;
                    gap_n      = 8'd0;
                    state_n    = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_n = S_IDLE;
                else                     gap_n   = gap_cnt + 8'd1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= 6'd0;
            addr_q    <= 2'd0;
            corrupt_q <= 1'b0;
            wr_idx    <= 6'd0;
            rd_idx    <= 6'd0;
            par_q     <= 8'd0;
            gap_cnt   <= 8'd0;
            to_cnt    <= 8'd0;
            pkt_data  <= 8'd0;
            pkt_valid <= 1'b0;
            done      <= 1'b0;
            bad_req   <= 1'b0;
        end else begin
            len_q     <= len_n;
            addr_q    <= addr_n;
            corrupt_q <= corrupt_n;
            wr_idx    <= wr_idx_n;
            rd_idx    <= rd_idx_n;
            par_q     <= par_n;
            gap_cnt   <= gap_n;
            to_cnt    <= to_n;
            pkt_data  <= pkt_data_n;
            pkt_valid <= pkt_valid_n;
            done      <= done_n;
            bad_req   <= bad_req_n;
        end
    end

    // Payload buffer write; contents need no reset.
    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[wr_idx] <= s_data;
    end

endmodule

// File: tb/tb_router_pkt_gen.sv
// tb_router_pkt_gen: directed bench for router_pkt_gen with hand-computed
// expectations; each comparison is an immediate assertion.
module tb_router_pkt_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic       corrupt_par;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       busy;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       tx_active;
    logic       done;
    logic       bad_req;
    logic [2:0] dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    router_pkt_gen #(
        .GAP_CYCLES  (2),
        .LOAD_TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dest_addr  (dest_addr),
        .pay_len    (pay_len),
        .corrupt_par(corrupt_par),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .busy       (busy),
        .pkt_data   (pkt_data),
        .pkt_valid  (pkt_valid),
        .tx_active  (tx_active),
        .done       (done),
        .bad_req    (bad_req),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Driver and checker tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic send_req(input logic [1:0] a, input logic [5:0] l, input logic c);
        start       = 1'b1;
        dest_addr   = a;
        pay_len     = l;
        corrupt_par = c;
        tick();
        start       = 1'b0;
        corrupt_par = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    // Check the presented byte and let busy=0 accept it.
    task automatic expect_out(input string tag, input logic [7:0] d, input logic v);
        check8(tag, pkt_data, d);
        check1({tag, "_valid"}, pkt_valid, v);
        tick();
    endtask

    // Parity byte, done pulse and the two-cycle gap back to IDLE.
    task automatic finish_packet(input string tag, input logic [7:0] par);
        check8({tag, "_par"}, pkt_data, par);
        check1({tag, "_par_valid"}, pkt_valid, 1'b0);
        check1({tag, "_done_early"}, done, 1'b0);
        tick();
        check1({tag, "_done"}, done, 1'b1);
        check8({tag, "_data_cleared"}, pkt_data, 8'h00);
        check1({tag, "_gap_valid"}, pkt_valid, 1'b0);
        tick();
        check1({tag, "_done_once"}, done, 1'b0);
        check1({tag, "_gap_active"}, tx_active, 1'b1);
        tick();
        check1({tag, "_idle"}, tx_active, 1'b0);
        check1({tag, "_idle_valid"}, pkt_valid, 1'b0);
    endtask

    // Directed sequence.
    initial begin
        logic [7:0] d;
        logic [7:0] p;
        int         n;

        reset       = 1'b1;
        start       = 1'b0;
        dest_addr   = 2'd0;
        pay_len     = 6'd0;
        corrupt_par = 1'b0;
        s_data      = 8'h00;
        s_valid     = 1'b0;
        busy        = 1'b0;
        repeat (3) tick();
        check8("rst_data", pkt_data, 8'h00);
        check1("rst_valid", pkt_valid, 1'b0);
        check1("rst_active", tx_active, 1'b0);
        check1("rst_sready", s_ready, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_badreq", bad_req, 1'b0);
        reset = 1'b0;
        tick();

        // Basic packet: addr 1, len 3, header 0x0D, parity 0x0D.
        send_req(2'd1, 6'd3, 1'b0);
        check1("t1_active", tx_active, 1'b1);
        check1("t1_sready", s_ready, 1'b1);
        load_byte(8'h11);
        load_byte(8'h22);
        load_byte(8'h33);
        check1("t1_sready_drop", s_ready, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        expect_out("t1_hdr", 8'h0D, 1'b1);
        s_valid = 1'b0;
        expect_out("t1_p0", 8'h11, 1'b1);
        expect_out("t1_p1", 8'h22, 1'b1);
        expect_out("t1_p2", 8'h33, 1'b1);
        check8("t1_par", pkt_data, 8'h0D);
        check1("t1_par_valid", pkt_valid, 1'b0);
        tick();
        check1("t1_done", done, 1'b1);
        tick();
        check1("t1_done_once", done, 1'b0);
        check1("t1_gap_valid", pkt_valid, 1'b0);
        // Request lands on the GAP->IDLE edge and must be ignored.
        start     = 1'b1;
        dest_addr = 2'd1;
        pay_len   = 6'd3;
        tick();
        start = 1'b0;
        check1("t1_gap_end_idle", tx_active, 1'b0);
        tick();
        check1("t1_start_in_gap_ignored", tx_active, 1'b0);
        check1("t1_start_in_gap_sready", s_ready, 1'b0);

        // Illegal requests.
        send_req(2'd3, 6'd5, 1'b0);
        check1("t3_badreq_addr", bad_req, 1'b1);
        check1("t3_active_addr", tx_active, 1'b0);
        check1("t3_valid_addr", pkt_valid, 1'b0);
        tick();
        check1("t3_badreq_addr_pulse", bad_req, 1'b0);
        send_req(2'd0, 6'd0, 1'b0);
        check1("t3_badreq_len", bad_req, 1'b1);
        check1("t3_active_len", tx_active, 1'b0);
        tick();
        check1("t3_badreq_len_pulse", bad_req, 1'b0);
        check1("t3_valid_len", pkt_valid, 1'b0);

        // Corrupted parity: addr 2, len 1, byte 0xA5 -> parity 0xA2.
        send_req(2'd2, 6'd1, 1'b1);
        load_byte(8'hA5);
        expect_out("t4_hdr", 8'h06, 1'b1);
        expect_out("t4_p0", 8'hA5, 1'b1);
        finish_packet("t4", 8'hA2);

        // Full-length packet with random gaps in s_valid.
        send_req(2'd2, 6'd63, 1'b0);
        p = 8'hFE;
        for (int i = 0; i < 63; i++) begin
            d = 8'(i * 7 + 3);
            p = p ^ d;
            n = $urandom_range(0, 2);
            repeat (n) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom_range(0, 255));
                tick();
            end
            if (i == 30) check1("t5_sready_mid", s_ready, 1'b1);
            load_byte(d);
        end
        expect_out("t5_hdr", 8'hFE, 1'b1);
        for (int i = 0; i < 63; i++) begin
            expect_out("t5_pay", 8'(i * 7 + 3), 1'b1);
        end
        finish_packet("t5", p);

        // Load timeout: four idle cycles in LOAD abort the request.
        send_req(2'd1, 6'd4, 1'b0);
        load_byte(8'h55);
        repeat (3) tick();
        check1("t5_to_active", tx_active, 1'b1);
        check1("t5_to_badreq_early", bad_req, 1'b0);
        tick();
        check1("t5_to_badreq", bad_req, 1'b1);
        check1("t5_to_idle", tx_active, 1'b0);
        check1("t5_to_sready", s_ready, 1'b0);
        tick();
        check1("t5_to_badreq_pulse", bad_req, 1'b0);

        // Asynchronous reset in the middle of the payload.
        send_req(2'd1, 6'd3, 1'b0);
        load_byte(8'h11);
        load_byte(8'h22);
        load_byte(8'h33);
        tick();
        check8("t6_in_pay", pkt_data, 8'h11);
        reset = 1'b1;
        #1;
        check8("t6_rst_data", pkt_data, 8'h00);
        check1("t6_rst_valid", pkt_valid, 1'b0);
        check1("t6_rst_active", tx_active, 1'b0);
        check1("t6_rst_sready", s_ready, 1'b0);
        check1("t6_rst_done", done, 1'b0);
        check1("t6_rst_badreq", bad_req, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check1("t6_no_done", done, 1'b0);
        check1("t6_idle", tx_active, 1'b0);

        // Same packet with busy held for four cycles on byte 0x22.
        send_req(2'd1, 6'd3, 1'b0);
        load_byte(8'h11);
        load_byte(8'h22);
        load_byte(8'h33);
        expect_out("t2_hdr", 8'h0D, 1'b1);
        expect_out("t2_p0", 8'h11, 1'b1);
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check8("t2_hold", pkt_data, 8'h22);
            check1("t2_hold_valid", pkt_valid, 1'b1);
        end
        busy = 1'b0;
        expect_out("t2_p1", 8'h22, 1'b1);
        expect_out("t2_p2", 8'h33, 1'b1);
        finish_packet("t2", 8'h0D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
